// File: rtl/pid_input_sequencer_if.sv
// pid_input_sequencer_if: shadow-write, step-trigger and sample-stream bundle
interface pid_input_sequencer_if #(parameter int DW = 64);
  logic          wr_en;
  logic [31:0]   wr_addr;
  logic [DW-1:0] wr_data;
  logic          step_start;
  logic          done_read;
  logic          sta;
  logic [DW-1:0] x;
  logic          x_valid;
  logic          busy;
  logic          step_done;
  logic          overrun;
  logic          addr_err;
  modport master (
    output wr_en, wr_addr, wr_data, step_start,
    input  done_read, sta, x, x_valid, busy, step_done, overrun, addr_err
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, step_start,
    output done_read, sta, x, x_valid, busy, step_done, overrun, addr_err
  );
endinterface

// File: rtl/pid_input_sequencer.sv
// pid_input_sequencer: snapshots per-channel samples and streams them after a fixed lead
module pid_input_sequencer #(
  parameter int N_CH = 8,
  parameter int LEAD = 11,
  parameter int DW   = 64
) (
  input logic                  clk,
  input logic                  rst,
  pid_input_sequencer_if.slave bus
);
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int CW = LEAD > 1 ? $clog2(LEAD) : 1;
  typedef enum logic [1:0] {S_IDLE, S_LEAD, S_STREAM} state_t;
  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic [DW-1:0] shadow [N_CH];
  logic [DW-1:0] snap   [N_CH];
  logic [DW-1:0] x;
  logic          done_read, overrun, addr_err, accept, wr_ok, last;
  assign accept = state == S_IDLE && bus.step_start;
  assign wr_ok  = bus.wr_en && bus.wr_addr < 32'(N_CH);
  assign last   = idx == IW'(N_CH - 1);
  always_comb begin
    nxt   = state;
    cnt_n = cnt;
    idx_n = idx;
    case (state)
      S_IDLE:   if (bus.step_start) begin nxt = S_LEAD; cnt_n = CW'(LEAD - 1); end
      S_LEAD:   if (cnt == '0) begin nxt = S_STREAM; idx_n = '0; end else cnt_n = cnt - 1'b1;
      S_STREAM: if (last) nxt = S_IDLE; else idx_n = idx + 1'b1;
      default:  nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end
  // x is loaded one cycle ahead so it lines up with the registered STREAM state
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N_CH; i++) begin
        shadow[i] <= '0;
        snap[i]   <= '0;
      end
      x         <= '0;
      done_read <= 1'b0;
      overrun   <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      if (wr_ok) shadow[bus.wr_addr[IW-1:0]] <= bus.wr_data;
      if (accept) snap <= shadow;
      if (nxt == S_STREAM) x <= snap[idx_n];
      done_read <= accept;
      overrun   <= overrun | (bus.step_start && state != S_IDLE);
      addr_err  <= addr_err | (bus.wr_en && !wr_ok);
    end
  end
  assign bus.done_read = done_read;
  assign bus.x         = x;
  assign bus.x_valid   = state == S_STREAM;
  assign bus.busy      = state != S_IDLE;
  assign bus.sta       = state == S_STREAM && idx == '0;
  assign bus.step_done = state == S_STREAM && last;
  assign bus.overrun   = overrun;
  assign bus.addr_err  = addr_err;
endmodule

// File: doc/pid_input_sequencer.md
# pid_input_sequencer

Per-step input sequencer for the time-multiplexed wind-turbine PID stages. Holds the latest 64-bit sample for each of N channels. On a step trigger it snapshots all channels, raises `done_read` a fixed lead time ahead, then issues `sta` and streams the N snapshot samples back-to-back on `x`, one channel per clock. It sits directly upstream of the PID initial/recursive stage and drives that stage's `sta`, `done_read` and `x` inputs.

## Interface

Parameters:
- `N_CH`, default `` `N_WindTurbine `` (8): number of channels per step; must be ≥ 1.
- `LEAD`, default 11: cycles from `done_read` to `sta`; must be ≥ 1.
- `DW`, default `` `EXTENDED_SINGLE `` (64): sample width.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  shadow-write strobe.
- `wr_addr`  in  `` `SINGLE `` (32)  channel index for the write.
- `wr_data`  in  DW  sample to store.
- `step_start`  in  1  single-cycle step trigger.
- `done_read`  out  1  one-cycle pulse, LEAD cycles before `sta`.
- `sta`  out  1  one-cycle pulse coincident with channel 0 on `x`.
- `x`  out  DW  streamed sample.
- `x_valid`  out  1  high for the N_CH stream cycles.
- `busy`  out  1  a step is in progress.
- `step_done`  out  1  one-cycle pulse with the last channel.
- `overrun`  out  1  sticky: `step_start` arrived while busy.
- `addr_err`  out  1  sticky: write to a channel ≥ N_CH.

## Operation

- Shadow bank: N_CH × DW registers, sample-and-hold.
  - With `wr_en`=1 and `wr_addr` < N_CH, `shadow[wr_addr]` <= `wr_data`.
  - Channels that are not rewritten keep their previous value.
  - With `wr_en`=1 and `wr_addr` ≥ N_CH, the write is dropped and `addr_err` is set.
- Snapshot bank: N_CH × DW registers, loaded from the whole shadow bank in the cycle a step is accepted.
  - The snapshot takes pre-write shadow contents. A write in the same cycle as an accepted `step_start` lands in shadow and is used by the next step, not this one.
- FSM states: IDLE, LEAD, STREAM.
  - IDLE: `step_start`=1 is accepted. Load the snapshot, set the lead counter to LEAD-1, go to LEAD, pulse `done_read` next cycle.
  - LEAD: count down to 0, then go to STREAM with channel index 0.
  - STREAM: output `x` = `snap[idx]` and `x_valid`=1. Increment idx. When idx = N_CH-1, pulse `step_done` and return to IDLE.
- `busy` = (state ≠ IDLE).
  - `step_start` while busy is ignored (no restart, snapshot untouched) and sets `overrun`.
- `x` holds the last streamed value (channel N_CH-1) after the stream until the next stream begins.
- `overrun` and `addr_err` clear only on reset.
- Reset (`rst`=0), including mid-step:
  - state=IDLE, counters=0, shadow and snapshot cleared to 0.
  - All outputs are 0, including `x`.
  - An interrupted step produces no further pulses.

## Timing

- Accepted `step_start` at cycle T (registered outputs):
  - `done_read`=1 at T+1.
  - `sta`=1 and `x_valid`=1 with `x`=`snap[0]` at T+1+LEAD.
  - `x`=`snap[k]` at T+1+LEAD+k for k = 0..N_CH-1.
  - `step_done`=1 at T+LEAD+N_CH.
- `busy`=1 from T+1 through T+LEAD+N_CH, and 0 at T+LEAD+N_CH+1.
- Earliest next accepted `step_start` is cycle T+LEAD+N_CH+1. A step_start in cycle T+LEAD+N_CH (busy still high) is rejected and sets `overrun`.
- No gaps within the stream; `x_valid` is exactly N_CH consecutive cycles.
- N_CH=1: `sta` and `step_done` assert in the same cycle.

## Test plan

- Reset, then write channel k = 64'h3FF0000000000000 + k for k = 0..7 and pulse `step_start` at T (LEAD=11, N_CH=8).
  - `done_read` at T+1, `sta` at T+12.
  - `x` sequence equals the written values at T+12..T+19.
  - `step_done` at T+19, `busy` low at T+20.
- Rewrite only channel 3 to 64'h4000000000000000 and step again.
  - Stream equals the previous values except channel 3 = 64'h4000000000000000.
- Write channel 0 = 64'hC000000000000000 in the same cycle as `step_start`.
  - Stream shows the old channel 0 value.
  - The following step shows 64'hC000000000000000.
- `step_start` at T+5 and again at T+18 of an active step.
  - Both are ignored and the stream is unchanged.
  - `overrun`=1 and stays set.
  - `step_start` at T+20 is accepted.
- Write with `wr_addr`=8.
  - `addr_err`=1 and shadow is unchanged.
  - Pull `rst` low at T+14 of a step: all outputs are 0 next cycle, no `step_done`, both flags cleared, and the next step streams zeros.
